// File: rtl/point_stream_collector_if.sv
// Pixel-stream-in / frame-RAM-write-out bundle for point_stream_collector.
// master = driving stage + RAM side observer, slave = the collector.
interface point_stream_collector_if #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 17
);
   logic              start;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              frame_done;
   logic [31:0]       checksum;

   modport master (
      output start, in_ready, in_data,
      input  wr_en, wr_addr, wr_data, busy, frame_done, checksum
   );

   modport slave (
      input  start, in_ready, in_data,
      output wr_en, wr_addr, wr_data, busy, frame_done, checksum
   );
endinterface

// File: rtl/point_stream_collector.sv
// Raster-orders a valid-qualified pixel stream into frame-RAM writes, one frame per start pulse.
// Optional frame checksum accumulator enabled by POINT_COLLECTOR_CHECKSUM_EN.
module point_stream_collector #(
   parameter int color_channels = 3,
   parameter int color_width    = 8,
   parameter int im_width       = 320,
   parameter int im_height      = 240,
   parameter int addr_width     = 17
) (
   input  logic                     clk,
   input  logic                     rst_n,
   point_stream_collector_if.slave  bus
);
   localparam int DATA_W = color_channels * color_width;
   localparam int XW     = (im_width  > 1) ? $clog2(im_width)  : 1;
   localparam int YW     = (im_height > 1) ? $clog2(im_height) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

   state_t                r_state;
   logic [XW-1:0]         r_x;
   logic [YW-1:0]         r_y;
   logic [addr_width-1:0] r_addr;
   logic                  r_wr_en;
   logic [addr_width-1:0] r_wr_addr;
   logic [DATA_W-1:0]     r_wr_data;
   logic                  r_busy;
   logic                  r_frame_done;

   logic w_x_last;
   logic w_y_last;

   assign w_x_last = (r_x == XW'(im_width - 1));
   assign w_y_last = (r_y == YW'(im_height - 1));

   // Address runs as its own counter so the raster address needs no y*width product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_addr       <= '0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= S_CAPTURE;
                  r_x     <= '0;
                  r_y     <= '0;
                  r_addr  <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_CAPTURE: begin
               if (bus.in_ready) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_addr;
                  r_wr_data <= bus.in_data;
                  r_addr    <= r_addr + 1'b1;
                  if (w_x_last) begin
                     r_x <= '0;
                     r_y <= r_y + 1'b1;
                     if (w_y_last) begin
                        r_state <= S_DONE;
                     end
                  end else begin
                     r_x <= r_x + 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state      <= S_IDLE;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wr_en      = r_wr_en;
   assign bus.wr_addr    = r_wr_addr;
   assign bus.wr_data    = r_wr_data;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_frame_done;

`ifdef POINT_COLLECTOR_CHECKSUM_EN
   logic [31:0] r_checksum;

   // Accumulates on the registered write, so the last pixel lands in the frame_done cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_checksum <= '0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_checksum <= '0;
      end else if (r_wr_en) begin
         r_checksum <= r_checksum + 32'(r_wr_data);
      end
   end

   assign bus.checksum = r_checksum;
`else
   assign bus.checksum = 32'd0;
`endif

endmodule
